// File: rtl/mul_add_chk_pkg.sv
// Shared header for the divider / multiply-add checker pair.
// Widths, latency and per-cell transistor costs.
package mul_add_chk_pkg;

    localparam int QW  = 8;
    localparam int BW  = 5;
    localparam int AW  = QW + BW;
    localparam int LAT = 5;
    localparam int NW  = 51;

    localparam int T_AND2 = 6;
    localparam int T_INV  = 2;
    localparam int T_NOR5 = 10;
    localparam int T_HA   = 14;
    localparam int T_FA   = 28;
    localparam int T_FS   = 28;
    localparam int T_DFF  = 26;

    // Four inner banks shed one divisor bit each; final bank is a+err+ovf+vld
    localparam int BANK_BITS = 4 * (AW + QW + 2) + (BW - 1) * BW / 2 + AW + 3;

    localparam int FIXED_CELLS = BANK_BITS * T_DFF
                               + BW * T_FS + T_INV
                               + T_NOR5 + T_INV;

    function automatic logic [NW-1:0] stage_cells(input int k);
        return NW'(QW * T_AND2 + T_HA + (QW - 1) * T_FA + (BW - k) * T_HA);
    endfunction

endpackage

// File: rtl/mul_add_chk_if.sv
// Valid-only triple-in / result-out bundle of the multiply-add checker.
interface mul_add_chk_if;
    import mul_add_chk_pkg::*;

    logic          i_in_valid;
    logic [QW-1:0] i_q;
    logic [BW-1:0] i_b;
    logic [BW-1:0] i_r;
    logic [AW-1:0] o_a;
    logic          o_r_err;
    logic          o_ovf;
    logic          o_out_valid;

    modport master (
        output i_in_valid, i_q, i_b, i_r,
        input  o_a, o_r_err, o_ovf, o_out_valid
    );

    modport slave (
        input  i_in_valid, i_q, i_b, i_r,
        output o_a, o_r_err, o_ovf, o_out_valid
    );

endinterface

// File: rtl/mul_add_chk_stage.sv
// One shift-add step: acc + (b[K] ? q<<K : 0) as gated ripple chain.
// Bits below K pass through; HA at K, FAs over q, HA carry tail above.
module mul_add_stage
    import mul_add_chk_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [AW-1:0] i_acc,
    input  logic [QW-1:0] i_q,
    input  logic          i_bk,
    output logic [AW-1:0] o_acc,
    output logic [NW-1:0] number
);

    logic [QW-1:0]   w_pp;
    logic [AW-1:K+1] w_c;

    assign w_pp   = i_q & {QW{i_bk}};
    assign number = stage_cells(K);

    for (genvar gi = 0; gi < AW; gi++) begin : g_bit
        if (gi < K) begin : g_pass
            assign o_acc[gi] = i_acc[gi];
        end else if (gi == K) begin : g_ha0
            assign o_acc[gi]  = i_acc[gi] ^ w_pp[0];
            assign w_c[gi+1]  = i_acc[gi] & w_pp[0];
        end else if (gi < K + QW) begin : g_fa
            logic w_p;
            assign w_p        = i_acc[gi] ^ w_pp[gi-K];
            assign o_acc[gi]  = w_p ^ w_c[gi];
            assign w_c[gi+1]  = (i_acc[gi] & w_pp[gi-K]) | (w_c[gi] & w_p);
        end else if (gi < AW - 1) begin : g_ha
            assign o_acc[gi]  = i_acc[gi] ^ w_c[gi];
            assign w_c[gi+1]  = i_acc[gi] & w_c[gi];
        end else begin : g_top
            // Max result 7936 fits in AW bits, so the final carry is dropped
            assign o_acc[gi]  = i_acc[gi] ^ w_c[gi];
        end
    end

endmodule

// File: rtl/mul_add_chk.sv
// In-line checker behind the divider: rebuilds a = q*b + r in 5 stages,
// flags r >= b and results beyond the 8-bit dividend range.
module mul_add_chk
    import mul_add_chk_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mul_add_chk_if.slave  bus,
    output logic [NW-1:0] number
);

    logic [BW:0]    w_bw;
    logic           w_r_err;
    logic           w_nor;
    logic [LAT-1:0] w_bk;
    logic [AW-1:0]  w_acc_in [LAT];
    logic [QW-1:0]  w_q_in   [LAT];
    logic [AW-1:0]  w_acc    [LAT];
    logic [NW-1:0]  w_num    [LAT];

    logic [AW-1:0]  r_acc [LAT-1];
    logic [QW-1:0]  r_q   [LAT-1];
    logic [LAT-2:0] r_vld;
    logic [LAT-2:0] r_err;
    logic [3:0]     r_b0;
    logic [2:0]     r_b1;
    logic [1:0]     r_b2;
    logic           r_b3;
    logic [AW-1:0]  r_a;
    logic           r_a_err;
    logic           r_ovf;
    logic           r_out_vld;

    // r >= b exactly when r - b produces no borrow
    assign w_bw[0] = 1'b0;
    for (genvar gi = 0; gi < BW; gi++) begin : g_cmp
        assign w_bw[gi+1] = (~bus.i_r[gi] & bus.i_b[gi])
                          | (~(bus.i_r[gi] ^ bus.i_b[gi]) & w_bw[gi]);
    end
    assign w_r_err = ~w_bw[BW];

    assign w_acc_in[0] = {{(AW-BW){1'b0}}, bus.i_r};
    assign w_q_in[0]   = bus.i_q;
    assign w_bk        = {r_b3, r_b2[0], r_b1[0], r_b0[0], bus.i_b[0]};

    for (genvar gk = 1; gk < LAT; gk++) begin : g_link
        assign w_acc_in[gk] = r_acc[gk-1];
        assign w_q_in[gk]   = r_q[gk-1];
    end

    for (genvar gk = 0; gk < LAT; gk++) begin : g_stage
        mul_add_stage #(.K(gk)) u_stage (
            .i_acc  (w_acc_in[gk]),
            .i_q    (w_q_in[gk]),
            .i_bk   (w_bk[gk]),
            .o_acc  (w_acc[gk]),
            .number (w_num[gk])
        );
    end

    assign w_nor = ~|w_acc[LAT-1][AW-1:QW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT - 1; k++) begin
                r_acc[k] <= '0;
                r_q[k]   <= '0;
            end
            r_vld     <= '0;
            r_err     <= '0;
            r_b0      <= '0;
            r_b1      <= '0;
            r_b2      <= '0;
            r_b3      <= 1'b0;
            r_a       <= '0;
            r_a_err   <= 1'b0;
            r_ovf     <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_acc[0] <= w_acc[0];
            r_q[0]   <= bus.i_q;
            r_vld[0] <= bus.i_in_valid;
            r_err[0] <= w_r_err;
            for (int k = 1; k < LAT - 1; k++) begin
                r_acc[k] <= w_acc[k];
                r_q[k]   <= r_q[k-1];
                r_vld[k] <= r_vld[k-1];
                r_err[k] <= r_err[k-1];
            end
            r_b0      <= bus.i_b[BW-1:1];
            r_b1      <= r_b0[3:1];
            r_b2      <= r_b1[2:1];
            r_b3      <= r_b2[1];
            r_a       <= w_acc[LAT-1];
            r_a_err   <= r_err[LAT-2];
            r_ovf     <= ~w_nor;
            r_out_vld <= r_vld[LAT-2];
        end
    end

    assign bus.o_a         = r_a;
    assign bus.o_r_err     = r_a_err;
    assign bus.o_ovf       = r_ovf;
    assign bus.o_out_valid = r_out_vld;

    always_comb begin
        number = NW'(FIXED_CELLS);
        for (int k = 0; k < LAT; k++) begin
            number = number + w_num[k];
        end
    end

endmodule

// File: tb/tb_mul_add_chk.sv
// Directed bench for mul_add_chk: vector table, latency, reset, loopback.
module tb_mul_add_chk;
    import mul_add_chk_pkg::*;

    typedef struct {
        logic          v;
        logic [QW-1:0] q;
        logic [BW-1:0] b;
        logic [BW-1:0] r;
        logic [AW-1:0] ea;
        logic          ee;
        logic          eo;
    } vec_t;

    localparam int NV = 12;
    localparam logic [NW-1:0] CELLS = NW'(4722);

    logic          clk;
    logic          rst_n;
    logic [NW-1:0] number;
    int            total;
    int            bad;
    vec_t          tv [NV];
    int unsigned   expq [$];

    mul_add_chk_if bus ();

    mul_add_chk dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .number (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int q, input int b, input int r);
        bus.i_in_valid = v;
        bus.i_q        = QW'(q);
        bus.i_b        = BW'(b);
        bus.i_r        = BW'(r);
    endtask

    task automatic chk_out(input string nm, input vec_t e);
        chk({nm, ".vld"}, bus.o_out_valid, e.v);
        if (e.v) begin
            chk({nm, ".a"}, bus.o_a, e.ea);
            chk({nm, ".err"}, bus.o_r_err, e.ee);
            chk({nm, ".ovf"}, bus.o_ovf, e.eo);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tv[0]  = '{1'b1,  28,  7,  4,  200, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 255,  1,  0,  255, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 170, 31, 31,    0, 1'b0, 1'b0};
        tv[3]  = '{1'b1,   3,  5,  2,   17, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 255,  0,  5,    5, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 255, 31, 30, 7935, 1'b0, 1'b1};
        tv[6]  = '{1'b1,   1,  5,  5,   10, 1'b1, 1'b0};
        tv[7]  = '{1'b1,   0, 31,  0,    0, 1'b0, 1'b0};
        tv[8]  = '{1'b1,  16, 16,  0,  256, 1'b0, 1'b1};
        tv[9]  = '{1'b1,  51,  5,  0,  255, 1'b0, 1'b0};
        tv[10] = '{1'b1,  51,  5,  1,  256, 1'b0, 1'b1};
        tv[11] = '{1'b1,   8, 31, 31,  279, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst.vld", bus.o_out_valid, 0);
        chk("rst.a", bus.o_a, 0);
        chk("rst.err", bus.o_r_err, 0);
        chk("rst.ovf", bus.o_ovf, 0);
        chk("number", number, CELLS);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single triple: valid exactly 5 edges after capture
        drive(1'b1, 28, 7, 4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 0);
            chk($sformatf("lat.c%0d", c), bus.o_out_valid, c == 5);
            if (c == 5) begin
                chk("lat.a", bus.o_a, 200);
                chk("lat.err", bus.o_r_err, 0);
                chk("lat.ovf", bus.o_ovf, 0);
            end
        end

        // table streamed back to back, bubbles included
        for (int j = 0; j < NV + 5; j++) begin
            @(negedge clk);
            if (j >= 5) chk_out($sformatf("tv%0d", j - 5), tv[j-5]);
            else chk("tv.idle", bus.o_out_valid, 0);
            if (j < NV) drive(tv[j].v, tv[j].q, tv[j].b, tv[j].r);
            else drive(1'b0, 0, 0, 0);
        end

        // async reset with triples still in flight
        repeat (3) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 255, 31, 30 - j);
            @(negedge clk);
        end
        drive(1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("pre.vld", bus.o_out_valid, 1);
        chk("pre.a", bus.o_a, 7935);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.vld", bus.o_out_valid, 0);
        chk("arst.a", bus.o_a, 0);
        chk("arst.ovf", bus.o_ovf, 0);
        chk("arst.err", bus.o_r_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("post.c%0d", c), bus.o_out_valid, 0);
        end

        // loopback over every legal divider result
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 32; b++) begin
                @(negedge clk);
                if (bus.o_out_valid) begin
                    if (expq.size() == 0) begin
                        chk("loop.extra", 1, 0);
                    end else begin
                        int unsigned ea;
                        ea = expq.pop_front();
                        chk("loop", {bus.o_ovf, bus.o_r_err, bus.o_a}, ea);
                    end
                end
                drive(1'b1, a / b, b, a % b);
                expq.push_back(a);
            end
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, 0);
            if (bus.o_out_valid) begin
                if (expq.size() == 0) begin
                    chk("loop.extra", 1, 0);
                end else begin
                    int unsigned ea;
                    ea = expq.pop_front();
                    chk("loop", {bus.o_ovf, bus.o_r_err, bus.o_a}, ea);
                end
            end
        end
        chk("loop.left", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
